// File: rtl/btn_edge_conditioner.sv
// Push-button front-end: per-channel synchroniser, debouncer, edge detector and
// optional hold-to-repeat, producing registered level/rise/fall/pulse outputs.
module btn_edge_conditioner #(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 100,
    parameter int REPEAT_RATE     = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] pulse
);
    localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = $clog2(RMAX + 1);

    localparam logic [DCW-1:0] DCNT_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RPT
    } rpt_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [DCW-1:0]         r_dcnt;
            logic                   r_level;
            logic                   r_rise;
            logic                   r_fall;
            logic                   r_pulse;
            rpt_state_t             r_state;
            rpt_state_t             w_state_next;
            logic [RCW-1:0]         r_rcnt;
            logic [RCW-1:0]         w_rcnt_next;
            logic                   w_s;
            logic                   w_accept;
            logic                   w_rise;
            logic                   w_fall;
            logic                   w_rep;
            logic                   w_edge;

            assign w_s      = r_sync[SYNC_STAGES-1];
            assign w_accept = (w_s != r_level) && (r_dcnt == DCNT_LAST);
            assign w_rise   = w_accept & ~r_level;
            assign w_fall   = w_accept & r_level;

            if (EDGE_MODE == 0) begin : g_edge_rise
                assign w_edge = w_rise;
            end else if (EDGE_MODE == 1) begin : g_edge_fall
                assign w_edge = w_fall;
            end else begin : g_edge_both
                assign w_edge = w_rise | w_fall;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync  <= '0;
                    r_dcnt  <= '0;
                    r_level <= 1'b0;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                    r_pulse <= 1'b0;
                    r_state <= ST_IDLE;
                    r_rcnt  <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], btn[gi]};
                    // Any sample agreeing with the accepted level restarts the run.
                    if ((w_s == r_level) || w_accept) begin
                        r_dcnt <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                    if (w_accept) begin
                        r_level <= ~r_level;
                    end
                    r_rise  <= w_rise;
                    r_fall  <= w_fall;
                    r_pulse <= w_edge | w_rep;
                    r_state <= w_state_next;
                    r_rcnt  <= w_rcnt_next;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_rcnt_next  = r_rcnt;
                w_rep        = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if ((REPEAT_EN != 0) && w_rise) begin
                            w_state_next = ST_HOLD;
                            w_rcnt_next  = '0;
                        end
                    end
                    ST_HOLD: begin
                        // A release wins over a tick landing in the same cycle.
                        if (w_fall) begin
                            w_state_next = ST_IDLE;
                            w_rcnt_next  = '0;
                        end else if (r_rcnt == DELAY_LAST) begin
                            w_rep        = 1'b1;
                            w_rcnt_next  = '0;
                            w_state_next = ST_RPT;
                        end else begin
                            w_rcnt_next = r_rcnt + 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (w_fall) begin
                            w_state_next = ST_IDLE;
                            w_rcnt_next  = '0;
                        end else if (r_rcnt == RATE_LAST) begin
                            w_rep       = 1'b1;
                            w_rcnt_next = '0;
                        end else begin
                            w_rcnt_next = r_rcnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                        w_rcnt_next  = '0;
                    end
                endcase
            end

            assign level[gi] = r_level;
            assign rise[gi]  = r_rise;
            assign fall[gi]  = r_fall;
            assign pulse[gi] = r_pulse;
        end
    endgenerate
endmodule

// File: tb/tb_btn_edge_conditioner.sv
// Bench for btn_edge_conditioner: one repeat-enabled rising-edge instance and one
// both-edges instance without repeat, checked every cycle against a queue of planned events.
module tb_btn_edge_conditioner;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int DELAY = 8;
    localparam int RATE  = 3;
    localparam int LAT   = SYNC + DEB;

    localparam int K_RISE  = 0;
    localparam int K_FALL  = 1;
    localparam int K_PULSE = 2;

    typedef struct {
        int cyc;
        int inst;
        int kind;
        int ch;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_a, level_a, rise_a, fall_a, pulse_a;
    logic [3:0] btn_b, level_b, rise_b, fall_b, pulse_b;

    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    ev_t sb_q[$];
    logic [3:0] lvl_a = 4'h0;
    logic [3:0] lvl_b = 4'h0;

    btn_edge_conditioner #(
        .N(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0),
        .REPEAT_EN(1), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn(btn_a),
        .level(level_a), .rise(rise_a), .fall(fall_a), .pulse(pulse_a)
    );

    btn_edge_conditioner #(
        .N(4), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(2),
        .REPEAT_EN(0), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn(btn_b),
        .level(level_b), .rise(rise_b), .fall(fall_b), .pulse(pulse_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // Press driven just after edge tp, released just after edge tr. Instance 0 pulses
    // on rise plus repeat ticks strictly before the fall; instance 1 pulses on both edges.
    task automatic plan(input int inst, input int ch, input int tp, input int tr);
        int t0;
        int tf;
        t0 = tp + LAT;
        tf = tr + LAT;
        sb_q.push_back('{t0, inst, K_RISE, ch});
        sb_q.push_back('{tf, inst, K_FALL, ch});
        sb_q.push_back('{t0, inst, K_PULSE, ch});
        if (inst == 0) begin
            for (int p = t0 + DELAY; p < tf; p += RATE) begin
                sb_q.push_back('{p, inst, K_PULSE, ch});
            end
        end else begin
            sb_q.push_back('{tf, inst, K_PULSE, ch});
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] er_a, ef_a, ep_a, er_b, ef_b, ep_b;
        int idx;
        er_a = 4'h0; ef_a = 4'h0; ep_a = 4'h0;
        er_b = 4'h0; ef_b = 4'h0; ep_b = 4'h0;
        idx = 0;
        while (idx < sb_q.size()) begin
            if (sb_q[idx].cyc == cyc) begin
                if (sb_q[idx].inst == 0) begin
                    if (sb_q[idx].kind == K_RISE)      er_a[sb_q[idx].ch] = 1'b1;
                    else if (sb_q[idx].kind == K_FALL) ef_a[sb_q[idx].ch] = 1'b1;
                    else                               ep_a[sb_q[idx].ch] = 1'b1;
                end else begin
                    if (sb_q[idx].kind == K_RISE)      er_b[sb_q[idx].ch] = 1'b1;
                    else if (sb_q[idx].kind == K_FALL) ef_b[sb_q[idx].ch] = 1'b1;
                    else                               ep_b[sb_q[idx].ch] = 1'b1;
                end
                sb_q.delete(idx);
            end else begin
                idx++;
            end
        end
        if (!rst_n) begin
            lvl_a = 4'h0;
            lvl_b = 4'h0;
        end else begin
            lvl_a = (lvl_a | er_a) & ~ef_a;
            lvl_b = (lvl_b | er_b) & ~ef_b;
        end
        check("rise_a", rise_a, er_a);
        check("fall_a", fall_a, ef_a);
        check("pulse_a", pulse_a, ep_a);
        check("level_a", level_a, lvl_a);
        check("rise_b", rise_b, er_b);
        check("fall_b", fall_b, ef_b);
        check("pulse_b", pulse_b, ep_b);
        check("level_b", level_b, lvl_b);
    end

    initial begin
        int k;
        int r;
        rst_n = 1'b1;
        btn_a = 4'h0;
        btn_b = 4'h0;
        #1;
        rst_n = 1'b0;
        btn_a = 4'hF;

        // Buttons held through reset release count as fresh presses.
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        r = cyc;
        for (int ch = 0; ch < 4; ch++) plan(0, ch, r, r + 12);
        wait_to(r + 12);
        btn_a = 4'h0;
        wait_to(r + 20);

        // Bounce: each high run is one cycle short of the debounce window.
        k = cyc;
        btn_a[0] = 1'b1;
        wait_to(k + 3);
        btn_a[0] = 1'b0;
        wait_to(k + 4);
        btn_a[0] = 1'b1;
        wait_to(k + 7);
        btn_a[0] = 1'b0;
        wait_to(k + 17);

        // Level stays high exactly DELAY cycles: the tick coincides with the fall and is dropped.
        k = cyc;
        plan(0, 1, k, k + 8);
        btn_a[1] = 1'b1;
        wait_to(k + 8);
        btn_a[1] = 1'b0;
        wait_to(k + 18);

        k = cyc;
        plan(0, 2, k, k + 30);
        btn_a[2] = 1'b1;
        wait_to(k + 30);
        btn_a[2] = 1'b0;
        wait_to(k + 40);

        k = cyc;
        plan(1, 3, k, k + 10);
        btn_b[3] = 1'b1;
        wait_to(k + 10);
        btn_b[3] = 1'b0;
        wait_to(k + 20);

        // Reset lands mid-cycle while channel 2 is repeating.
        k = cyc;
        plan(0, 2, k, k + 1000);
        btn_a[2] = 1'b1;
        wait_to(k + 21);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("async_level_a", level_a, 4'h0);
        check("async_rise_a", rise_a, 4'h0);
        check("async_fall_a", fall_a, 4'h0);
        check("async_pulse_a", pulse_a, 4'h0);
        check("async_level_b", level_b, 4'h0);
        check("async_pulse_b", pulse_b, 4'h0);
        btn_a = 4'hF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r = cyc;
        for (int ch = 0; ch < 4; ch++) plan(0, ch, r, r + 12);
        wait_to(r + 12);
        btn_a = 4'h0;
        wait_to(r + 30);

        total++;
        assert (sb_q.size() == 0)
        else begin
            bad++;
            $error("FAIL sb_empty observed=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
